content_ram_arbiter: RTL and testbench
======================================

Name: content_ram_arbiter

Overview:
- Shares the single-port content RAM between two requesters:
  - the PIT write path, which stores content bytes arriving from the FIB;
  - the user read-out path, which streams a stored entry to user_data.
- Grants whole bursts (entry address plus byte count) and drives the RAM address, byte, write-enable and data.
- Returns read data with the RAM's one-cycle latency.
- Sits between PIT, FIB data path and single_port_ram, replacing their direct RAM wiring.

Parameters:
- ADDR_W, 10, RAM entry address width
- BYTE_W, 10, byte-offset width; a burst is at most 2^BYTE_W bytes
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_req  in  1  write burst request; hold until wr_done
- wr_addr  in  ADDR_W  entry to write; sampled at grant
- wr_len  in  BYTE_W  burst length in bytes; 0 encodes 2^BYTE_W; sampled at grant
- wr_valid  in  1  wr_data valid this cycle; honoured only while wr_gnt is high
- wr_data  in  DATA_W  write byte
- wr_gnt  out  1  write burst owns the RAM
- wr_done  out  1  one-cycle pulse with the last byte written
- rd_req  in  1  read burst request; hold until rd_done
- rd_addr  in  ADDR_W  entry to read; sampled at grant
- rd_len  in  BYTE_W  read length; same encoding as wr_len
- rd_gnt  out  1  read burst owns the RAM
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  read byte, equal to ram_q
- rd_last  out  1  marks the final rd_valid byte
- rd_done  out  1  pulse coincident with rd_last
- ram_addr  out  ADDR_W  to RAM addr
- ram_byte  out  BYTE_W  to RAM byte
- ram_we  out  1  to RAM we
- ram_data  out  DATA_W  to RAM data
- ram_q  in  DATA_W  from RAM q (registered, one-cycle latency)
- busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high.
- Reset values:
  - state=IDLE, byte_cnt=0, last_grant=RD.
  - All outputs are 0: gnt, done, rd_valid, rd_last, ram_we, busy, and ram_addr/ram_byte/ram_data.
  - ram_we is additionally gated by !rst, so a write never occurs in the reset cycle.
- States: IDLE, WR, RD.
- IDLE:
  - Requests are arbitrated in IDLE only.
  - With one request, that side is chosen. With both, the side other than last_grant is chosen (round-robin).
  - The chosen side's addr and len are latched, byte_cnt is cleared, last_grant is updated, and the state moves to WR or RD. gnt goes high the cycle after the request is seen.
- WR:
  - wr_gnt=1. ram_addr=latched address, ram_byte=byte_cnt, ram_data=wr_data, ram_we=wr_valid.
  - byte_cnt increments on wr_valid.
  - On wr_valid with byte_cnt==len-1 (mod 2^BYTE_W): wr_done=1 in that cycle and the next state is IDLE.
  - wr_valid low stalls with no timeout.
- RD:
  - rd_gnt=1. ram_byte=byte_cnt every cycle, ram_we=0, byte_cnt increments each cycle.
  - One cycle later: rd_valid=1 and rd_data=ram_q. rd_last and rd_done are high for the byte issued at len-1.
  - After issuing the last address the state returns to IDLE. The final rd_valid appears during that IDLE cycle.
- Bus-idle minimum: at least one IDLE cycle separates bursts. A single requester therefore sees gnt again no earlier than 2 cycles after its done.
- Abort: req dropping while granted aborts the burst.
  - Next state is IDLE, with no done pulse.
  - The pending read byte is suppressed (rd_valid=0).
  - Bytes already written stay in RAM.
- Wrap-around: len=0 yields exactly 2^BYTE_W bytes, and byte_cnt wraps to 0 at the end.
- Simultaneous events:
  - Requests arriving while busy wait; there is no preemption.
  - wr_valid outside WR is ignored.
- Reset mid-burst: takes effect on the next edge. There is no done pulse and no further rd_valid.

Optional Feature:
- Macro: CONTENT_ARB_WR_PRIORITY_EN.
- Defined: on a tie in IDLE, write always wins (fixed priority, last_grant ignored). This ensures content arriving from the FIB is never back-pressured by user read-out.
- Undefined: round-robin as specified above.

Decomposition:
- ndn_pkg: constants NDN_ADDR_W=10, NDN_BYTE_W=10, NDN_DATA_W=8, and the typedef enum arb_state_t {IDLE, WR, RD}.
- One sub-module, rr_arb2:
  - combinational two-way pick from req_a, req_b and last_grant;
  - honours CONTENT_ARB_WR_PRIORITY_EN.
- The burst counter and FSM stay in content_ram_arbiter.

Test Plan:
- Write only, wr_addr=5, wr_len=3, bytes AA,BB,CC with wr_valid held high → ram_we on 3 cycles at ram_byte 0,1,2 with ram_addr=5; wr_done with byte CC; then read 5/3 returns AA,BB,CC with rd_last on CC.
- wr_req and rd_req both rise the cycle after reset → write granted first; read granted after wr_done plus one IDLE cycle. A second tie → read wins. With CONTENT_ARB_WR_PRIORITY_EN defined → write wins both ties.
- Write burst len=4 with wr_valid pattern 1,0,0,1,1,1 → exactly 4 RAM writes at bytes 0..3; wr_done on the 6th granted cycle.
- Read len=0 from entry 7 → 1024 rd_valid beats, bytes 0..1023; rd_last on beat 1024; byte_cnt back to 0.
- rd_req dropped after 2 of 8 addresses issued → state IDLE next cycle; no rd_done, no rd_last; rd_valid only for the bytes whose addresses were issued before the drop.
- rst asserted during a WR burst with wr_valid high → ram_we=0 in the reset cycle; all outputs 0 the following cycle; a fresh request is then granted normally.

Source files
------------

// File: rtl/ndn_pkg.sv
// Shared constants and the arbiter state encoding for the NDN content RAM slice.
package ndn_pkg;
  localparam int NDN_ADDR_W = 10;
  localparam int NDN_BYTE_W = 10;
  localparam int NDN_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, WR, RD} arb_state_t;
endpackage

// File: rtl/content_ram_arbiter_if.sv
// Burst request/response bus between PIT/FIB/user paths, the arbiter and the content RAM.
// master = requesters plus RAM (drive req/addr/len/data and ram_q); slave = content_ram_arbiter.
interface content_ram_if
  import ndn_pkg::*;
#(
  parameter int ADDR_W = NDN_ADDR_W,
  parameter int BYTE_W = NDN_BYTE_W,
  parameter int DATA_W = NDN_DATA_W
);
  logic              wr_req, wr_valid, wr_gnt, wr_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [BYTE_W-1:0] wr_len;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req, rd_gnt, rd_valid, rd_last, rd_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [BYTE_W-1:0] rd_len;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [BYTE_W-1:0] ram_byte;
  logic              ram_we;
  logic [DATA_W-1:0] ram_data, ram_q;

  modport master (
    output wr_req, wr_addr, wr_len, wr_valid, wr_data, rd_req, rd_addr, rd_len, ram_q,
    input  wr_gnt, wr_done, rd_gnt, rd_valid, rd_data, rd_last, rd_done,
           ram_addr, ram_byte, ram_we, ram_data
  );
  modport slave (
    input  wr_req, wr_addr, wr_len, wr_valid, wr_data, rd_req, rd_addr, rd_len, ram_q,
    output wr_gnt, wr_done, rd_gnt, rd_valid, rd_data, rd_last, rd_done,
           ram_addr, ram_byte, ram_we, ram_data
  );
endinterface

// File: rtl/content_ram_arbiter_rr_arb2.sv
// Two-way combinational pick: round-robin on ties, or fixed write (a) priority when
// CONTENT_ARB_WR_PRIORITY_EN is defined.
module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic gnt_a,
  output logic gnt_b
);
`ifdef CONTENT_ARB_WR_PRIORITY_EN
  logic unused_last_b;
  assign unused_last_b = last_b;
  assign gnt_a = req_a;
  assign gnt_b = req_b & ~req_a;
`else
  // on a tie the side that did not win last time goes next
  assign gnt_a = req_a & (~req_b | last_b);
  assign gnt_b = req_b & (~req_a | ~last_b);
`endif
endmodule

// File: rtl/content_ram_arbiter.sv
// Shares the single-port content RAM between the PIT write path and the user read-out path
// in whole bursts. CONTENT_ARB_WR_PRIORITY_EN selects fixed write priority on ties.
module content_ram_arbiter
  import ndn_pkg::*;
#(
  parameter int ADDR_W = NDN_ADDR_W,
  parameter int BYTE_W = NDN_BYTE_W,
  parameter int DATA_W = NDN_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  content_ram_if.slave bus,
  output logic         busy
);
  arb_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] len_q, len_m1, byte_cnt;
  logic              last_rd, rd_valid_q, rd_last_q;
  logic              pick_wr, pick_rd, is_last, wr_fire, rd_issue;

  // len 0 encodes 2^BYTE_W, so the wrapped len-1 is all ones
  assign len_m1   = len_q - 1'b1;
  assign is_last  = (byte_cnt == len_m1);
  assign wr_fire  = (state == WR) && bus.wr_req && bus.wr_valid;
  assign rd_issue = (state == RD) && bus.rd_req;

  // A reader holds rd_req through its rd_done cycle, which lands in IDLE; mask it there
  // so the finished burst is not granted a second time.
  rr_arb2 u_arb (
    .req_a (bus.wr_req),
    .req_b (bus.rd_req && !rd_last_q),
    .last_b(last_rd),
    .gnt_a (pick_wr),
    .gnt_b (pick_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      last_rd    <= 1'b1;
      addr_q     <= '0;
      len_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      rd_last_q  <= rd_issue && is_last;
      case (state)
        IDLE: begin
          if (pick_wr || pick_rd) begin
            state    <= pick_wr ? WR : RD;
            addr_q   <= pick_wr ? bus.wr_addr : bus.rd_addr;
            len_q    <= pick_wr ? bus.wr_len : bus.rd_len;
            byte_cnt <= '0;
            last_rd  <= pick_rd;
          end
        end
        WR: begin
          if (!bus.wr_req) state <= IDLE;
          else if (bus.wr_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (is_last) state <= IDLE;
          end
        end
        RD: begin
          if (!bus.rd_req) state <= IDLE;
          else begin
            byte_cnt <= byte_cnt + 1'b1;
            if (is_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign bus.wr_gnt   = (state == WR);
  assign bus.rd_gnt   = (state == RD);
  assign bus.wr_done  = wr_fire && is_last && !rst;
  assign bus.ram_we   = wr_fire && !rst;
  assign bus.ram_addr = busy ? addr_q : {ADDR_W{1'b0}};
  assign bus.ram_byte = busy ? byte_cnt : {BYTE_W{1'b0}};
  assign bus.ram_data = (state == WR) ? bus.wr_data : {DATA_W{1'b0}};
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_done  = rd_last_q;
  assign bus.rd_data  = bus.ram_q;
endmodule

// File: tb/tb_content_ram_arbiter.sv
// Self-checking bench for content_ram_arbiter: random bursts checked against a byte-level
// reference memory plus grant-timing rules. Honours CONTENT_ARB_WR_PRIORITY_EN.
module tb_content_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  content_ram_if bus ();
  content_ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));

  // single-port RAM with registered read
  logic [7:0] ram_mem [bit [19:0]];
  always @(posedge clk) begin : ram_model
    bit [19:0] k;
    k = {bus.ram_addr, bus.ram_byte};
    bus.ram_q <= ram_mem.exists(k) ? ram_mem[k] : 8'h00;
    if (bus.ram_we === 1'b1) ram_mem[k] = bus.ram_data;
  end

  // reference content: what each entry/byte should hold after the bursts the bench issued
  logic [7:0] ref_mem [bit [19:0]];
  function automatic logic [7:0] ref_rd(input bit [19:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_write(input logic [9:0] a, input int n, input bit use_pat, input logic [31:0] pat,
                           input bit fixed, output int gnt_c, output int done_c, output int gcnt);
    int sent, budget;
    bit fin, last;
    logic [29:0] obs, exp;
    sent = 0; budget = 0; fin = 0; gnt_c = -1; done_c = -1; gcnt = 0;
    bus.wr_addr = a; bus.wr_len = n[9:0]; bus.wr_req = 1'b1;
    while (!fin) begin
      if (bus.wr_gnt) bus.wr_valid = use_pat ? pat[gcnt[4:0]] : ($urandom_range(3) != 0);
      else bus.wr_valid = 1'($urandom_range(1));
      bus.wr_data = fixed ? 8'(8'hAA + 8'h11 * sent) : 8'($urandom);
      @(negedge clk);
      if (bus.wr_gnt) begin
        if (gnt_c < 0) gnt_c = cyc;
        gcnt++;
        last = bus.wr_valid && (sent == n - 1);
        exp = {bus.wr_valid, last, a, bus.wr_valid ? 10'(sent) : 10'd0, bus.wr_valid ? bus.wr_data : 8'd0};
        obs = {bus.ram_we, bus.wr_done, bus.ram_addr, bus.wr_valid ? bus.ram_byte : 10'd0,
               bus.wr_valid ? bus.ram_data : 8'd0};
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL wr_cycle: got we/done/addr/byte/data=%h want %h", obs, exp);
        end
        if (bus.wr_valid) begin ref_mem[{a, 10'(sent)}] = bus.wr_data; sent++; end
        if (sent == n) begin done_c = cyc; fin = 1; end
      end else begin
        checks++;
        if ({bus.ram_we, bus.wr_done} !== 2'b00) begin
          errors++; $display("FAIL wr_ungranted: got we,done=%b%b want 00", bus.ram_we, bus.wr_done);
        end
      end
      if (++budget > 5000) begin errors++; $display("FAIL wr_timeout: got sent=%0d want %0d", sent, n); fin = 1; end
      tick();
    end
    bus.wr_req = 1'b0; bus.wr_valid = 1'b0;
  endtask

  task automatic run_read(input logic [9:0] a, input int n, output int gnt_c, output int done_c);
    int issued, beats, budget;
    bit fin, last;
    issued = 0; beats = 0; budget = 0; fin = 0; gnt_c = -1; done_c = -1;
    bus.rd_addr = a; bus.rd_len = n[9:0]; bus.rd_req = 1'b1;
    while (!fin) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        last = (beats == n - 1);
        checks++;
        if ({bus.rd_data, bus.rd_last, bus.rd_done} !== {ref_rd({a, 10'(beats)}), last, last}) begin
          errors++; $display("FAIL rd_beat %0d: got data=%h last=%b done=%b want %h %b %b", beats,
                             bus.rd_data, bus.rd_last, bus.rd_done, ref_rd({a, 10'(beats)}), last, last);
        end
        beats++;
        if (bus.rd_last || last) begin done_c = cyc; fin = 1; end
      end
      if (bus.rd_gnt) begin
        if (gnt_c < 0) gnt_c = cyc;
        checks++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_byte} !== {1'b0, a, 10'(issued)}) begin
          errors++; $display("FAIL rd_issue: got we/addr/byte=%b/%h/%h want 0/%h/%h", bus.ram_we,
                             bus.ram_addr, bus.ram_byte, a, 10'(issued));
        end
        issued++;
      end
      if (++budget > 5000) begin errors++; $display("FAIL rd_timeout: got beats=%0d want %0d", beats, n); fin = 1; end
      tick();
    end
    bus.rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rd_gnt !== 1'b0) begin errors++; $display("FAIL rd_no_regrant: got rd_gnt=%b want 0", bus.rd_gnt); end
    tick();
  endtask

  task automatic check_all_zero(input string nm);
    logic [35:0] v;
    v = {bus.wr_gnt, bus.wr_done, bus.rd_gnt, bus.rd_valid, bus.rd_last, bus.rd_done, bus.ram_we, busy,
         bus.ram_addr, bus.ram_byte, bus.ram_data};
    checks++;
    if (v !== 36'd0) begin errors++; $display("FAIL %s: got outputs=%h want 0", nm, v); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset_state");
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    int wg, wd, wn, rg, rd, c0;
    c0 = cyc;
    fork
      run_write(10'd20, 4, 1'b0, 32'd0, 1'b0, wg, wd, wn);
      run_read(10'd20, 3, rg, rd);
    join
    checks++;
    if (wg != c0 + 1 || rg != wd + 2) begin
      errors++; $display("FAIL tie1_order: got wr_gnt@%0d rd_gnt@%0d want %0d %0d", wg, rg, c0 + 1, wd + 2);
    end
    run_write(10'd21, 2, 1'b0, 32'd0, 1'b0, wg, wd, wn);
    c0 = cyc;
    fork
      run_write(10'd22, 3, 1'b0, 32'd0, 1'b0, wg, wd, wn);
      run_read(10'd21, 2, rg, rd);
    join
    checks++;
`ifdef CONTENT_ARB_WR_PRIORITY_EN
    if (wg != c0 + 1 || rg != wd + 2) begin
      errors++; $display("FAIL tie2_order: got wr_gnt@%0d rd_gnt@%0d want %0d %0d", wg, rg, c0 + 1, wd + 2);
    end
`else
    if (rg != c0 + 1 || wg != rd + 1) begin
      errors++; $display("FAIL tie2_order: got rd_gnt@%0d wr_gnt@%0d want %0d %0d", rg, wg, c0 + 1, rd + 1);
    end
`endif
  endtask

  task automatic test_write_basic();
    int g, d, n, c0;
    c0 = cyc;
    run_write(10'd5, 3, 1'b1, 32'hFFFF_FFFF, 1'b1, g, d, n);
    checks++;
    if (g != c0 + 1 || d != g + 2) begin
      errors++; $display("FAIL wr_basic_timing: got gnt@%0d done@%0d want %0d %0d", g, d, c0 + 1, c0 + 3);
    end
    c0 = cyc;
    run_read(10'd5, 3, g, d);
    checks++;
    if (g != c0 + 1 || d != g + 3) begin
      errors++; $display("FAIL rd_basic_timing: got gnt@%0d done@%0d want %0d %0d", g, d, c0 + 1, c0 + 4);
    end
  endtask

  task automatic test_valid_pattern();
    int g, d, n;
    run_write(10'd9, 4, 1'b1, 32'h0000_0039, 1'b0, g, d, n);
    checks++;
    if (n != 6 || d != g + 5) begin
      errors++; $display("FAIL wr_stall: got granted_cycles=%0d done_offset=%0d want 6 5", n, d - g);
    end
    run_read(10'd9, 4, g, d);
  endtask

  task automatic test_read_abort();
    int issued, beats, budget, bad;
    issued = 0; beats = 0; budget = 0; bad = 0;
    bus.rd_addr = 10'd5; bus.rd_len = 10'd8; bus.rd_req = 1'b1;
    while (issued < 2 && budget < 50) begin
      @(negedge clk);
      if (bus.rd_valid) beats++;
      if (bus.rd_gnt) issued++;
      budget++;
      tick();
    end
    bus.rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        checks++;
        if (bus.rd_data !== ref_rd({10'd5, 10'(beats)})) begin
          errors++; $display("FAIL abort_data: got %h want %h", bus.rd_data, ref_rd({10'd5, 10'(beats)}));
        end
        beats++;
      end
      if (bus.rd_last || bus.rd_done) bad++;
      if (i == 1) begin
        checks++;
        if ({busy, bus.rd_gnt} !== 2'b00) begin
          errors++; $display("FAIL abort_idle: got busy,rd_gnt=%b%b want 00", busy, bus.rd_gnt);
        end
      end
      tick();
    end
    checks++;
    if (issued != 2 || beats != 2 || bad != 0) begin
      errors++; $display("FAIL abort_beats: got issued=%0d beats=%0d last/done=%0d want 2 2 0", issued, beats, bad);
    end
  endtask

  task automatic test_wrap();
    int g, d, n;
    run_write(10'd7, 1024, 1'b0, 32'd0, 1'b0, g, d, n);
    run_read(10'd7, 1024, g, d);
    checks++;
    if (d != g + 1024) begin
      errors++; $display("FAIL wrap_len: got last_beat_offset=%0d want 1024", d - g);
    end
  endtask

  task automatic test_reset_mid_burst();
    int g, budget, wg, wd, wn, c0;
    g = 0; budget = 0;
    bus.wr_addr = 10'd33; bus.wr_len = 10'd8; bus.wr_req = 1'b1; bus.wr_valid = 1'b0;
    while (g < 2 && budget < 50) begin
      bus.wr_valid = bus.wr_gnt;
      bus.wr_data = 8'($urandom);
      @(negedge clk);
      if (bus.wr_gnt && bus.wr_valid) begin ref_mem[{10'd33, 10'(g)}] = bus.wr_data; g++; end
      budget++;
      tick();
    end
    rst = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'h5A;
    @(negedge clk);
    checks++;
    if ({bus.ram_we, bus.wr_done} !== 2'b00) begin
      errors++; $display("FAIL rst_cycle_we: got we,done=%b%b want 00", bus.ram_we, bus.wr_done);
    end
    tick();
    rst = 1'b0; bus.wr_req = 1'b0; bus.wr_valid = 1'b0;
    @(negedge clk);
    check_all_zero("after_mid_reset");
    tick();
    c0 = cyc;
    run_write(10'd34, 3, 1'b0, 32'd0, 1'b0, wg, wd, wn);
    checks++;
    if (wg != c0 + 1) begin errors++; $display("FAIL post_reset_gnt: got %0d want %0d", wg, c0 + 1); end
    run_read(10'd33, 4, wg, wd);
  endtask

  task automatic test_random();
    int g, d, n, c0;
    logic [9:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 10'($urandom_range(100, 200));
      c0 = cyc;
      run_write(a, $urandom_range(1, 16), 1'b0, 32'd0, 1'b0, g, d, n);
      checks++;
      if (g != c0 + 1) begin errors++; $display("FAIL rand_wr_gnt: got %0d want %0d", g, c0 + 1); end
      c0 = cyc;
      run_read(a, $urandom_range(1, 20), g, d);
      checks++;
      if (g != c0 + 1) begin errors++; $display("FAIL rand_rd_gnt: got %0d want %0d", g, c0 + 1); end
    end
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_len = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_len = '0;
    test_reset();
    test_tie();
    test_write_basic();
    test_valid_pattern();
    test_read_abort();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
